text_pixel_gen: RTL and testbench

//  Text-mode pixel pipeline between VGA timing generator and pixel output. Maps (hcnt,vcnt) to an
//  80x30 text buffer cell, fetches the char code, forms the 11-bit glyph address for the 128x16 font
//  ROM (2048 x 8b, registered read) and emits one monochrome pixel per clk_i. Sync/DE re-aligned.

---
 rtl/vga_pkg.sv | 37 +++
 rtl/text_pixel_gen_delay_line.sv | 33 +++
 rtl/text_pixel_gen.sv | 150 +++++++++++++++
 tb/tb_text_pixel_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Purpose: shared constants for the text-mode pixel pipeline: visible area,
//          cell geometry, text/font address widths, sync polarity and the
//          cursor blink bit. Also holds the cell address helper (row*80 + col
//          built from shifts and an add).
// Ports:   none (package).
package vga_pkg;

  localparam int H_VISIBLE        = 640;
  localparam int V_VISIBLE        = 480;
  localparam int CELL_W           = 8;
  localparam int CELL_H           = 16;
  localparam int COLS             = 80;
  localparam int ROWS             = 30;
  localparam int TB_AW            = 12;
  localparam int FONT_AW          = 11;
  localparam int FONT_DW          = 8;
  localparam int CURSOR_BLINK_BIT = 4;
  localparam int FRAME_CNT_W      = 6;

  // Sync outputs from the timing generator are active-low.
  localparam logic HSYNC_ACTIVE = 1'b0;
  localparam logic VSYNC_ACTIVE = 1'b0;
  localparam logic HSYNC_IDLE   = 1'b1;
  localparam logic VSYNC_IDLE   = 1'b1;

  // First glyph row of the underline-style cursor (rows 14..15).
  localparam logic [3:0] CURSOR_FIRST_ROW = 4'd14;

  // row*80 + col as (row<<6) + (row<<4) + col. Only valid for COLS == 80.
  function automatic logic [TB_AW-1:0] cell_addr(input logic [4:0] row,
                                                  input logic [6:0] col);
    logic [TB_AW-1:0] r;
    r = {7'd0, row};
    return (r << 6) + (r << 4) + {5'd0, col};
  endfunction

endpackage

// File: rtl/text_pixel_gen_delay_line.sv
// Purpose: fixed-depth register delay line with a configurable reset value,
//          used to keep sync, DE and per-pixel side information aligned with
//          the text/font fetch pipeline.
// Ports:
//   clk_i   in   1      clock
//   rstn_i  in   1      async active-low reset (all taps load RST_VAL)
//   d_i     in   W      data in
//   q_o     out  W      d_i delayed by DEPTH clocks
module delay_line #(
  parameter int           W       = 1,
  parameter int           DEPTH   = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= RST_VAL;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/text_pixel_gen.sv
// Purpose: text-mode pixel pipeline. Maps (hcnt,vcnt) to an 80x30 text cell,
//          fetches the char code from an external text buffer, forms the font
//          ROM address {char[6:0], glyph_row[3:0]} and selects one monochrome
//          pixel from the returned glyph row. Char bit 7 inverts the cell.
//          Stream interface: no valid/ready; one pixel enters and one leaves
//          every clock, fixed 3-clock latency for pixel_o/de_o/hsync_o/vsync_o.
// Optional feature: macro CURSOR_EN adds a blinking underline cursor
//          (cursor_col_i, cursor_row_i, cursor_on_i) driven by a frame counter
//          that advances on each vsync_i falling edge.
// Ports:
//   clk_i        in   1        pixel clock
//   rstn_i       in   1        async active-low reset
//   hcnt_i       in   10       horizontal pixel counter
//   vcnt_i       in   10       vertical line counter
//   de_i         in   1        display enable
//   hsync_i      in   1        hsync (active-low)
//   vsync_i      in   1        vsync (active-low)
//   tbuf_addr_o  out  12       text buffer address (registered)
//   tbuf_data_i  in   8        char code, valid the clock after tbuf_addr_o
//   font_addr_o  out  11       font ROM address (registered)
//   font_data_i  in   [0:7]    glyph row, bit 0 = leftmost pixel
//   pixel_o      out  1        pixel on/off
//   de_o         out  1        de_i aligned with pixel_o
//   hsync_o      out  1        hsync_i aligned with pixel_o
//   vsync_o      out  1        vsync_i aligned with pixel_o
//   cursor_col_i in   7        (CURSOR_EN) cursor column
//   cursor_row_i in   5        (CURSOR_EN) cursor row
//   cursor_on_i  in   1        (CURSOR_EN) cursor enable
module text_pixel_gen
  import vga_pkg::*;
(
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [9:0]         hcnt_i,
  input  logic [9:0]         vcnt_i,
  input  logic               de_i,
  input  logic               hsync_i,
  input  logic               vsync_i,
  output logic [TB_AW-1:0]   tbuf_addr_o,
  input  logic [7:0]         tbuf_data_i,
  output logic [FONT_AW-1:0] font_addr_o,
  input  logic [0:FONT_DW-1] font_data_i,
  output logic               pixel_o,
  output logic               de_o,
  output logic               hsync_o,
  output logic               vsync_o
`ifdef CURSOR_EN
  ,
  input  logic [6:0]         cursor_col_i,
  input  logic [4:0]         cursor_row_i,
  input  logic               cursor_on_i
`endif
);

  // Rows only need vcnt[8:4]; vcnt[9] is beyond the visible area.
  logic unused_vcnt_msb;
  assign unused_vcnt_msb = vcnt_i[9];

  // ---- S0: text buffer address ----
  logic [TB_AW-1:0] tbuf_addr_d, tbuf_addr_q;
  assign tbuf_addr_d = cell_addr(vcnt_i[8:4], hcnt_i[9:3]);

  // ---- S1: font address ----
  logic [3:0]         vrow_d1;
  logic [FONT_AW-1:0] font_addr_d, font_addr_q;
  assign font_addr_d = {tbuf_data_i[6:0], vrow_d1};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tbuf_addr_q <= '0;
      font_addr_q <= '0;
    end else begin
      tbuf_addr_q <= tbuf_addr_d;
      font_addr_q <= font_addr_d;
    end
  end

  assign tbuf_addr_o = tbuf_addr_q;
  assign font_addr_o = font_addr_q;

  // ---- side-information alignment ----
  logic [2:0] hpix_d2;
  logic       inv_d2;
  logic       de_d2;

  delay_line #(.W(4), .DEPTH(1)) u_vrow (
    .clk_i(clk_i), .rstn_i(rstn_i), .d_i(vcnt_i[3:0]), .q_o(vrow_d1));
  delay_line #(.W(3), .DEPTH(2)) u_hpix (
    .clk_i(clk_i), .rstn_i(rstn_i), .d_i(hcnt_i[2:0]), .q_o(hpix_d2));
  // Inverse flag arrives with the char code one stage after S0.
  delay_line #(.W(1), .DEPTH(1)) u_inv (
    .clk_i(clk_i), .rstn_i(rstn_i), .d_i(tbuf_data_i[7]), .q_o(inv_d2));
  delay_line #(.W(1), .DEPTH(2)) u_de (
    .clk_i(clk_i), .rstn_i(rstn_i), .d_i(de_i), .q_o(de_d2));
  delay_line #(.W(1), .DEPTH(3), .RST_VAL(HSYNC_IDLE)) u_hs (
    .clk_i(clk_i), .rstn_i(rstn_i), .d_i(hsync_i), .q_o(hsync_o));
  delay_line #(.W(1), .DEPTH(3), .RST_VAL(VSYNC_IDLE)) u_vs (
    .clk_i(clk_i), .rstn_i(rstn_i), .d_i(vsync_i), .q_o(vsync_o));

  // ---- S2: pixel select ----
  logic font_bit;
  logic pixel_d, pixel_q, de_q;
  assign font_bit = font_data_i[hpix_d2];

`ifdef CURSOR_EN
  logic                   vs_prev_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_d, frame_cnt_q;
  logic                   blink;
  logic                   cur_s0, cur_d2;

  // Registered falling-edge detect of vsync_i drives the blink counter.
  assign frame_cnt_d = (vs_prev_q && !vsync_i) ? frame_cnt_q + 1'b1 : frame_cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vs_prev_q   <= VSYNC_IDLE;
      frame_cnt_q <= '0;
    end else begin
      vs_prev_q   <= vsync_i;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign blink  = frame_cnt_q[CURSOR_BLINK_BIT];
  assign cur_s0 = (vcnt_i[8:4] == cursor_row_i) && (hcnt_i[9:3] == cursor_col_i) &&
                  (vcnt_i[3:0] >= CURSOR_FIRST_ROW);

  delay_line #(.W(1), .DEPTH(2)) u_cur (
    .clk_i(clk_i), .rstn_i(rstn_i), .d_i(cur_s0), .q_o(cur_d2));

  assign pixel_d = de_d2 & ((cur_d2 & cursor_on_i & blink) | (font_bit ^ inv_d2));
`else
  assign pixel_d = de_d2 & (font_bit ^ inv_d2);
`endif

  // ---- S3: output register ----
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pixel_q <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      pixel_q <= pixel_d;
      de_q    <= de_d2;
    end
  end

  assign pixel_o = pixel_q;
  assign de_o    = de_q;

endmodule

// File: tb/tb_text_pixel_gen.sv
// Directed bench for text_pixel_gen. Text buffer and font ROM are modelled as
// arrays read at the DUT's registered address, so data is valid the clock
// after the address was formed. Inputs change 1 ns after posedge; outputs are
// sampled at the same point, i.e. away from the active edge.
module tb_text_pixel_gen;
  import vga_pkg::*;

  logic         clk = 1'b0;
  logic         rstn_i;
  logic [9:0]   hcnt_i, vcnt_i;
  logic         de_i, hsync_i, vsync_i;
  logic [11:0]  tbuf_addr_o;
  logic [7:0]   tbuf_data_i;
  logic [10:0]  font_addr_o;
  logic [0:7]   font_data_i;
  logic         pixel_o, de_o, hsync_o, vsync_o;
`ifdef CURSOR_EN
  logic [6:0]   cursor_col_i;
  logic [4:0]   cursor_row_i;
  logic         cursor_on_i;
`endif

  logic [7:0]   tbuf_mem [0:4095];
  logic [0:7]   font_mem [0:2047];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign tbuf_data_i = tbuf_mem[tbuf_addr_o];
  assign font_data_i = font_mem[font_addr_o];

  text_pixel_gen dut (
    .clk_i(clk), .rstn_i(rstn_i), .hcnt_i(hcnt_i), .vcnt_i(vcnt_i),
    .de_i(de_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .tbuf_addr_o(tbuf_addr_o), .tbuf_data_i(tbuf_data_i),
    .font_addr_o(font_addr_o), .font_data_i(font_data_i),
    .pixel_o(pixel_o), .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
`ifdef CURSOR_EN
    ,
    .cursor_col_i(cursor_col_i), .cursor_row_i(cursor_row_i),
    .cursor_on_i(cursor_on_i)
`endif
  );

  // ---------------- clock/reset and drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [9:0] h, input logic [9:0] v,
                       input logic de, input logic hs, input logic vs);
    hcnt_i  = h;
    vcnt_i  = v;
    de_i    = de;
    hsync_i = hs;
    vsync_i = vs;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    tick();
    tick();
    #2 rstn_i = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(10'd16, 10'd35, 1'b1, 1'b0, 1'b0);
    repeat (4) tick();
    n_checks++;
    if (pixel_o !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_pixel: got %b want 1", pixel_o);
    end
    #2 rstn_i = 1'b0;
    #1;
    n_checks++;
    if ({pixel_o, de_o, hsync_o, vsync_o} !== 4'b0011) begin
      n_fail++; $display("FAIL async_reset_outs: got %b want 0011", {pixel_o, de_o, hsync_o, vsync_o});
    end
    n_checks++;
    if (tbuf_addr_o !== 12'd0 || font_addr_o !== 11'd0) begin
      n_fail++; $display("FAIL async_reset_addr: got tbuf=%0d font=%0d want 0 0", tbuf_addr_o, font_addr_o);
    end
    tick();
    #2 rstn_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if (i < 3) begin
        if (pixel_o !== 1'b0 || de_o !== 1'b0 || hsync_o !== 1'b1) begin
          n_fail++; $display("FAIL release_clk%0d: got px=%b de=%b hs=%b want 0 0 1", i, pixel_o, de_o, hsync_o);
        end
      end else begin
        if (pixel_o !== 1'b1 || de_o !== 1'b1 || hsync_o !== 1'b0) begin
          n_fail++; $display("FAIL release_clk3: got px=%b de=%b hs=%b want 1 1 0", pixel_o, de_o, hsync_o);
        end
      end
    end
  endtask

  task automatic test_address();
    logic [9:0]  h_v [3] = '{10'd17, 10'd639, 10'd700};
    logic [9:0]  v_v [3] = '{10'd35, 10'd479, 10'd500};
    logic [11:0] ta  [3] = '{12'd162, 12'd2399, 12'd2567};
    logic [10:0] fa  [3] = '{11'h413, 11'h05F, 11'h004};
    for (int k = 0; k < 3; k++) begin
      drive(h_v[k], v_v[k], 1'b1, 1'b1, 1'b1);
      tick();
      n_checks++;
      if (tbuf_addr_o !== ta[k]) begin
        n_fail++; $display("FAIL tbuf_addr[%0d]: got %0d want %0d", k, tbuf_addr_o, ta[k]);
      end
      tick();
      n_checks++;
      if (font_addr_o !== fa[k]) begin
        n_fail++; $display("FAIL font_addr[%0d]: got %h want %h", k, font_addr_o, fa[k]);
      end
    end
  endtask

  task automatic test_pixel();
    logic ep, ed;
    for (int i = 0; i <= 10; i++) begin
      if (i < 8) drive(10'(16 + i), 10'd35, 1'b1, 1'b1, 1'b1);
      else       drive(10'd16, 10'd35, 1'b0, 1'b1, 1'b1);
      tick();
      if (i >= 2) begin
        ep = (i - 2 == 0) || (i - 2 == 7);
        ed = (i - 2 < 8);
        n_checks++;
        if (pixel_o !== ep || de_o !== ed) begin
          n_fail++; $display("FAIL pixel_x%0d: got px=%b de=%b want %b %b", i - 2, pixel_o, de_o, ep, ed);
        end
      end
    end
  endtask

  task automatic test_inverse();
    logic ep;
    for (int i = 0; i <= 10; i++) begin
      if (i < 8) drive(10'(24 + i), 10'd35, 1'b1, 1'b1, 1'b1);
      else       drive(10'd25, 10'd35, 1'b0, 1'b1, 1'b1);
      tick();
      if (i >= 2) begin
        ep = (i - 2 < 8) ? !((i - 2 == 0) || (i - 2 == 7)) : 1'b0;
        n_checks++;
        if (pixel_o !== ep) begin
          n_fail++; $display("FAIL inverse_x%0d: got %b want %b", i - 2, pixel_o, ep);
        end
      end
    end
  endtask

  task automatic test_sync_align();
    logic [13:0] hs_pat = 14'b11_1110_0011_0111;
    logic [13:0] vs_pat = 14'b11_1000_0111_1101;
    logic [13:0] de_pat = 14'b00_0111_1001_1110;
    for (int i = 0; i < 14; i++) begin
      drive(10'd16, 10'd35, de_pat[i], hs_pat[i], vs_pat[i]);
      tick();
      if (i >= 2) begin
        n_checks++;
        if (hsync_o !== hs_pat[i-2] || vsync_o !== vs_pat[i-2] ||
            de_o !== de_pat[i-2] || pixel_o !== de_pat[i-2]) begin
          n_fail++;
          $display("FAIL sync_align_%0d: got hs=%b vs=%b de=%b px=%b want %b %b %b %b",
                   i - 2, hsync_o, vsync_o, de_o, pixel_o,
                   hs_pat[i-2], vs_pat[i-2], de_pat[i-2], de_pat[i-2]);
        end
      end
    end
  endtask

`ifdef CURSOR_EN
  task automatic test_cursor();
    logic [9:0] ph [6] = '{10'd40, 10'd47, 10'd40, 10'd45, 10'd48, 10'd43};
    logic [9:0] pv [6] = '{10'd46, 10'd46, 10'd47, 10'd45, 10'd46, 10'd47};
    logic       ev [6];
    cursor_col_i = 7'd5;
    cursor_row_i = 5'd2;
    cursor_on_i  = 1'b1;
    drive(10'd40, 10'd46, 1'b1, 1'b1, 1'b1);
    do_reset();
    for (int pass = 0; pass < 3; pass++) begin
      // pass 0: count 0 (blink off); pass 1: count 16 (on); pass 2: count 32 (off)
      for (int i = 0; i < 6; i++) ev[i] = (pass == 1) && (i < 3 || i == 5);
      for (int i = 0; i < 8; i++) begin
        if (i < 6) drive(ph[i], pv[i], 1'b1, 1'b1, 1'b1);
        else       drive(ph[5], pv[5], 1'b1, 1'b1, 1'b1);
        tick();
        if (i >= 2) begin
          n_checks++;
          if (pixel_o !== ev[i-2]) begin
            n_fail++; $display("FAIL cursor_p%0d_%0d: got %b want %b", pass, i - 2, pixel_o, ev[i-2]);
          end
        end
      end
      for (int k = 0; k < 16; k++) begin
        drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
        tick();
      end
    end
  endtask
`endif

  // ---------------- main sequence and report ----------------
  initial begin
    for (int a = 0; a < 4096; a++) tbuf_mem[a] = 8'h00;
    for (int a = 0; a < 2048; a++) font_mem[a] = 8'h00;
    tbuf_mem[162]  = 8'h41;  // row 2, col 2
    tbuf_mem[163]  = 8'hC1;  // row 2, col 3, inverse
    tbuf_mem[2399] = 8'h85;  // row 29, col 79
    font_mem[11'h413] = 8'b1000_0001;
`ifdef CURSOR_EN
    cursor_col_i = 7'd0;
    cursor_row_i = 5'd0;
    cursor_on_i  = 1'b0;
`endif
    drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    do_reset();
    test_reset();
    test_address();
    test_pixel();
    test_inverse();
    test_sync_align();
`ifdef CURSOR_EN
    test_cursor();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
